// File: rtl/dvfs_multi_domain_governor.sv
// dvfs_multi_domain_governor
// Closed-loop DVFS governor for N_DOM power domains sharing one voltage
// regulator port. Each domain keeps an EMA-filtered utilisation, a settle timer
// and committed voltage/frequency levels. One level step is in flight at a time:
// voltage moves before frequency on the way up, and frequency moves before
// voltage on the way down, so that freq_level never exceeds volt_level.
module dvfs_multi_domain_governor #(
   parameter int N_DOM       = 4,
   parameter int LVL_W       = 3,
   parameter int MAX_LVL     = 7,
   parameter int RESET_LVL   = 2,
   parameter int EMA_SHIFT   = 3,
   parameter int SETTLE_W    = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [N_DOM*8-1:0]           util_in,
   input  logic [7:0]                   hi_thresh,
   input  logic [7:0]                   lo_thresh,
   input  logic [SETTLE_W-1:0]          settle_cfg,
   input  logic [7:0]                   temperature,
   input  logic [7:0]                   temp_limit,
   output logic                         vreg_req,
   output logic [$clog2(N_DOM)-1:0]     vreg_dom,
   output logic [LVL_W-1:0]             vreg_lvl,
   input  logic                         vreg_ack,
   input  logic                         err_clr,
   output logic [N_DOM*LVL_W-1:0]       volt_level,
   output logic [N_DOM*LVL_W-1:0]       freq_level,
   output logic [N_DOM*8-1:0]           util_ema,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int DOM_W  = $clog2(N_DOM);
   localparam int ACC_W  = 8 + EMA_SHIFT;
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [LVL_W-1:0]  MAX_L     = LVL_W'(MAX_LVL);
   localparam logic [LVL_W-1:0]  RST_L     = LVL_W'(RESET_LVL);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, UP_V, UP_F, DN_F, DN_V} state_t;

   state_t                state_q;
   logic [ACC_W-1:0]      acc_q    [N_DOM];
   logic [ACC_W-1:0]      acc_d    [N_DOM];
   logic [7:0]            ema_w    [N_DOM];
   logic [LVL_W-1:0]      volt_q   [N_DOM];
   logic [LVL_W-1:0]      freq_q   [N_DOM];
   logic [SETTLE_W-1:0]   settle_q [N_DOM];
   logic [DOM_W-1:0]      ptr_q;
   logic [DOM_W-1:0]      grant_q;
   logic [LVL_W-1:0]      tgt_q;
   logic [WAIT_W-1:0]     wait_q;
   logic                  req_q;
   logic                  err_q;
   logic [N_DOM-1:0]      up_pend;
   logic [N_DOM-1:0]      dn_pend;
   logic                  hot;
   logic                  found;
   logic [DOM_W-1:0]      pick;
   logic                  pick_up;

   // EMA next value: acc - acc/2^EMA_SHIFT + sample, settles at util<<EMA_SHIFT
   always_comb begin
      for (int d = 0; d < N_DOM; d++) begin
         acc_d[d] = acc_q[d] - (acc_q[d] >> EMA_SHIFT) + ACC_W'(util_in[8*d +: 8]);
      end
   end

   // EMA accumulators run every cycle, independent of enable
   always_ff @(posedge clk) begin
      for (int d = 0; d < N_DOM; d++) begin
         if (!reset) acc_q[d] <= '0;
         else        acc_q[d] <= acc_d[d];
      end
   end

   // Per-domain pending requests; thermal override only allows stepping down
   always_comb begin
      hot     = (temperature >= temp_limit);
      up_pend = '0;
      dn_pend = '0;
      for (int d = 0; d < N_DOM; d++) begin
         ema_w[d] = acc_q[d][ACC_W-1:EMA_SHIFT];
         if (settle_q[d] == '0) begin
            if (hot)                                          dn_pend[d] = (freq_q[d] != '0);
            else if ((ema_w[d] > hi_thresh) && (freq_q[d] < MAX_L)) up_pend[d] = 1'b1;
            else if ((ema_w[d] < lo_thresh) && (freq_q[d] != '0))   dn_pend[d] = 1'b1;
         end
      end
   end

   // Round-robin pick: first pending domain at or after the pointer
   always_comb begin
      int               idx;
      logic [DOM_W-1:0] cand;
      found   = 1'b0;
      pick    = '0;
      pick_up = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int i = 0; i < N_DOM; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_DOM) idx = idx - N_DOM;
         cand = DOM_W'(idx);
         if (!found && (up_pend[cand] || dn_pend[cand])) begin
            found   = 1'b1;
            pick    = cand;
            pick_up = up_pend[cand];
         end
      end
   end

   // Transition sequencer, regulator handshake, levels and settle timers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         tgt_q   <= '0;
         wait_q  <= '0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int d = 0; d < N_DOM; d++) begin
            volt_q[d]   <= RST_L;
            freq_q[d]   <= RST_L;
            settle_q[d] <= '0;
         end
      end else begin
         for (int d = 0; d < N_DOM; d++) begin
            if (settle_q[d] != '0) settle_q[d] <= settle_q[d] - 1'b1;
         end
         // a timeout in the same cycle overrides the clear below
         if (err_clr) err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable && found) begin
                  grant_q <= pick;
                  ptr_q   <= (pick == DOM_W'(N_DOM - 1)) ? '0 : pick + 1'b1;
                  wait_q  <= '0;
                  if (pick_up) begin
                     tgt_q   <= freq_q[pick] + 1'b1;
                     req_q   <= 1'b1;
                     state_q <= UP_V;
                  end else begin
                     tgt_q   <= freq_q[pick] - 1'b1;
                     state_q <= DN_F;
                  end
               end
            end
            UP_V, DN_V: begin
               if (vreg_ack) begin
                  req_q           <= 1'b0;
                  volt_q[grant_q] <= tgt_q;
                  if (state_q == UP_V) begin
                     state_q <= UP_F;
                  end else begin
                     settle_q[grant_q] <= settle_cfg;
                     state_q           <= IDLE;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  req_q             <= 1'b0;
                  err_q             <= 1'b1;
                  settle_q[grant_q] <= settle_cfg;
                  state_q           <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            UP_F: begin
               freq_q[grant_q]   <= tgt_q;
               settle_q[grant_q] <= settle_cfg;
               state_q           <= IDLE;
            end
            DN_F: begin
               freq_q[grant_q] <= tgt_q;
               req_q           <= 1'b1;
               wait_q          <= '0;
               state_q         <= DN_V;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Flatten per-domain registers onto the output buses
   always_comb begin
      volt_level = '0;
      freq_level = '0;
      util_ema   = '0;
      for (int d = 0; d < N_DOM; d++) begin
         volt_level[d*LVL_W +: LVL_W] = volt_q[d];
         freq_level[d*LVL_W +: LVL_W] = freq_q[d];
         util_ema[8*d +: 8]           = ema_w[d];
      end
   end

   assign vreg_req    = req_q;
   assign vreg_dom    = grant_q;
   assign vreg_lvl    = tgt_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = err_q;

endmodule
